// File: rtl/inst_ram_loader_if.sv
// Byte-stream / RAM-write bundle for the instruction RAM loader.
// master = stream source and status sink; slave = the loader.
interface inst_ram_loader_if #(
    parameter int AW = 6
) ();
    logic          start;
    logic [AW:0]   len;
    logic          abort;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic          we;
    logic [31:0]   waddr;
    logic [31:0]   wdata;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output start, len, abort, byte_in, byte_valid,
        input  byte_ready, we, waddr, wdata,
        input  cpu_hold, busy, done, err
    );

    modport slave (
        input  start, len, abort, byte_in, byte_valid,
        output byte_ready, we, waddr, wdata,
        output cpu_hold, busy, done, err
    );
endinterface

// File: rtl/inst_ram_loader.sv
// Packs an MSB-first byte stream into 32-bit words and writes them
// to the instruction RAM, holding the pipeline for the whole load.
module inst_ram_loader #(
    parameter int AW = 6
) (
    input  logic               i_clk,
    input  logic               i_clrn,
    inst_ram_loader_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [AW:0] LEN_MAX = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] LEN_ONE = {{AW{1'b0}}, 1'b1};

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW:0]     r_len;
    logic [AW-1:0]   r_word_idx;
    logic [1:0]      r_byte_cnt;
    logic [23:0]     r_shreg;
    logic [31:0]     r_waddr;
    logic [31:0]     r_wdata;
    logic            r_err;

    logic            w_len_ok;
    logic            w_xfer;
    logic            w_last;
    logic            w_err_set;
    logic            w_byte_ready;
    logic            w_we;
    logic            w_done;

    assign w_len_ok = (bus.len != '0) && (bus.len <= LEN_MAX);
    assign w_xfer   = bus.byte_valid & w_byte_ready;
    assign w_last   = ({1'b0, r_word_idx} == (r_len - LEN_ONE));

    // Bad length at start, or abort while a load is in flight
    assign w_err_set =
        ((r_state == S_IDLE) & bus.start & ~w_len_ok) |
        (((r_state == S_RECV) | (r_state == S_WRITE)) & bus.abort);

    always_ff @(posedge i_clk or negedge i_clrn) begin
        if (!i_clrn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_byte_ready = 1'b0;
        w_we         = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start && w_len_ok) begin
                    w_state_nxt = S_RECV;
                end
            end
            S_RECV: begin
                w_byte_ready = 1'b1;
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_xfer && (r_byte_cnt == 2'd3)) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_we        = 1'b1;
                    w_state_nxt = w_last ? S_DONE : S_RECV;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_clrn) begin
        if (!i_clrn) begin
            r_len      <= '0;
            r_word_idx <= '0;
            r_byte_cnt <= '0;
            r_shreg    <= '0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_err_set;
            case (r_state)
                S_IDLE: begin
                    if (bus.start && w_len_ok) begin
                        r_len      <= bus.len;
                        r_word_idx <= '0;
                        r_byte_cnt <= '0;
                    end
                end
                S_RECV: begin
                    if (w_xfer && !bus.abort) begin
                        r_shreg    <= {r_shreg[15:0], bus.byte_in};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        // Latch the write beat as the fourth byte lands
                        if (r_byte_cnt == 2'd3) begin
                            r_wdata <= {r_shreg, bus.byte_in};
                            r_waddr <= {{(30-AW){1'b0}}, r_word_idx, 2'b00};
                        end
                    end
                end
                S_WRITE: begin
                    if (!bus.abort && !w_last) begin
                        r_word_idx <= r_word_idx + 1'b1;
                        r_byte_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.byte_ready = w_byte_ready;
    assign bus.we         = w_we;
    assign bus.waddr      = r_waddr;
    assign bus.wdata      = r_wdata;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.cpu_hold   = (r_state != S_IDLE);
    assign bus.done       = w_done;
    assign bus.err        = r_err;
endmodule

// File: tb/tb_inst_ram_loader.sv
// Bench for inst_ram_loader: directed loads checked against a
// word-queue model of the byte stream.
module tb_inst_ram_loader;
    localparam int AW = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    inst_ram_loader_if #(.AW(AW)) bus ();

    inst_ram_loader #(.AW(AW)) dut (
        .i_clk  (clk),
        .i_clrn (rst_n),
        .bus    (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] exp_a[$];
    logic [31:0] exp_d[$];
    logic [31:0] log_a[$];
    logic [31:0] log_d[$];
    logic [31:0] m_word;
    int          m_nb;
    int          m_widx;
    int          done_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    // Model: every 4 accepted bytes form one word at the next address
    task automatic model_begin();
        m_nb   = 0;
        m_widx = 0;
        m_word = '0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        m_word = {m_word[23:0], b};
        m_nb++;
        if (m_nb == 4) begin
            exp_a.push_back(32'(m_widx * 4));
            exp_d.push_back(m_word);
            m_widx++;
            m_nb = 0;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.we) begin
                log_a.push_back(bus.waddr);
                log_d.push_back(bus.wdata);
                if (exp_a.size() == 0) begin
                    chk("we_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("waddr", bus.waddr, exp_a.pop_front());
                    chk("wdata", bus.wdata, exp_d.pop_front());
                end
            end
            chk("hold_vs_busy", 32'(bus.cpu_hold), 32'(bus.busy));
            if (bus.done) done_cnt++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [AW:0] l);
        model_begin();
        bus.start = 1'b1;
        bus.len   = l;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic ok;
        bus.byte_valid = 1'b0;
        repeat (gap) cyc();
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = bus.byte_ready;
            cyc();
        end
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'hxx;
        if (!ok) chk("byte_timeout", 32'd0, 32'd1);
        else     model_byte(b);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    logic [7:0] t1 [12] = '{8'h14, 8'h00, 8'h08, 8'h01,
                            8'h14, 8'h00, 8'h00, 8'h22,
                            8'h00, 8'h10, 8'h0c, 8'h41};
    logic [AW:0] bad_len [3] = '{7'd0, 7'd65, 7'd127};

    initial begin
        int d0;
        bus.start      = 1'b0;
        bus.len        = '0;
        bus.abort      = 1'b0;
        bus.byte_in    = '0;
        bus.byte_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  32'(bus.busy), 32'd0);
        chk("rst_hold",  32'(bus.cpu_hold), 32'd0);
        chk("rst_ready", 32'(bus.byte_ready), 32'd0);
        chk("rst_waddr", bus.waddr, 32'd0);
        chk("rst_wdata", bus.wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // 1: three-word load with latency checks
        log_a.delete();
        log_d.delete();
        start_load(7'd3);
        foreach (t1[i]) send_byte(t1[i], 0);
        @(negedge clk);
        chk("t1_we_lat", 32'(bus.we), 32'd1);
        chk("t1_done_early", 32'(bus.done), 32'd0);
        cyc();
        @(negedge clk);
        chk("t1_done", 32'(bus.done), 32'd1);
        chk("t1_busy_done", 32'(bus.busy), 32'd1);
        cyc();
        @(negedge clk);
        chk("t1_hold_low", 32'(bus.cpu_hold), 32'd0);
        chk("t1_done_gone", 32'(bus.done), 32'd0);
        chk("t1_nwrites", 32'(log_a.size()), 32'd3);
        chk("t1_w0", log_d[0], 32'h14000801);
        chk("t1_w1", log_d[1], 32'h14000022);
        chk("t1_w2", log_d[2], 32'h00100c41);
        chk("t1_a2", log_a[2], 32'h00000008);
        chk("t1_qempty", 32'(exp_a.size()), 32'd0);
        cyc();

        // 2: out-of-range lengths
        foreach (bad_len[i]) begin
            bus.start = 1'b1;
            bus.len   = bad_len[i];
            cyc();
            bus.start = 1'b0;
            @(negedge clk);
            chk("t2_err", 32'(bus.err), 32'd1);
            chk("t2_busy", 32'(bus.busy), 32'd0);
            chk("t2_hold", 32'(bus.cpu_hold), 32'd0);
            cyc();
            @(negedge clk);
            chk("t2_err_pulse", 32'(bus.err), 32'd0);
            cyc();
        end

        // 3: full 64-word load with random gaps
        log_a.delete();
        log_d.delete();
        d0 = done_cnt;
        start_load(7'd64);
        for (int i = 0; i < 256; i++) begin
            send_byte(8'($urandom), int'($urandom_range(0, 2)));
        end
        cyc();
        cyc();
        @(negedge clk);
        chk("t3_busy_low", 32'(bus.busy), 32'd0);
        chk("t3_nwrites", 32'(log_a.size()), 32'd64);
        chk("t3_last_addr", log_a[log_a.size()-1], 32'h000000fc);
        chk("t3_qempty", 32'(exp_a.size()), 32'd0);
        chk("t3_done_once", 32'(done_cnt - d0), 32'd1);
        cyc();

        // 4: reset in the middle of word 1
        start_load(7'd2);
        send_byte(8'h5a, 0);
        send_byte(8'h6b, 1);
        send_byte(8'h7c, 0);
        send_byte(8'h8d, 0);
        send_byte(8'h9e, 0);
        send_byte(8'haf, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4_rst_busy", 32'(bus.busy), 32'd0);
        chk("t4_rst_hold", 32'(bus.cpu_hold), 32'd0);
        chk("t4_rst_ready", 32'(bus.byte_ready), 32'd0);
        chk("t4_rst_we", 32'(bus.we), 32'd0);
        chk("t4_rst_wdata", bus.wdata, 32'd0);
        exp_a.delete();
        exp_d.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        log_a.delete();
        log_d.delete();
        start_load(7'd1);
        send_byte(8'ha1, 0);
        send_byte(8'hb2, 0);
        send_byte(8'hc3, 0);
        send_byte(8'hd4, 0);
        cyc();
        cyc();
        @(negedge clk);
        chk("t4_nwrites", 32'(log_a.size()), 32'd1);
        chk("t4_w0", log_d[0], 32'ha1b2c3d4);
        chk("t4_a0", log_a[0], 32'd0);
        chk("t4_qempty", 32'(exp_a.size()), 32'd0);
        cyc();

        // 5: abort in the WRITE cycle of word 1
        log_a.delete();
        log_d.delete();
        start_load(7'd4);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        send_byte(8'h77, 0);
        send_byte(8'h88, 0);
        bus.abort = 1'b1;
        @(negedge clk);
        chk("t5_we_abort", 32'(bus.we), 32'd0);
        cyc();
        bus.abort = 1'b0;
        @(negedge clk);
        chk("t5_err", 32'(bus.err), 32'd1);
        chk("t5_busy", 32'(bus.busy), 32'd0);
        chk("t5_hold", 32'(bus.cpu_hold), 32'd0);
        if (exp_a.size() > 0) begin
            void'(exp_a.pop_back());
            void'(exp_d.pop_back());
        end
        chk("t5_qempty", 32'(exp_a.size()), 32'd0);
        chk("t5_nwrites", 32'(log_a.size()), 32'd1);
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        @(negedge clk);
        chk("t5_idle_abort", 32'(bus.err), 32'd0);
        cyc();

        // 6: start pulse during RECV must be ignored
        log_a.delete();
        log_d.delete();
        d0 = done_cnt;
        start_load(7'd2);
        send_byte(8'hde, 0);
        send_byte(8'had, 0);
        bus.start = 1'b1;
        bus.len   = 7'd1;
        cyc();
        bus.start = 1'b0;
        send_byte(8'hbe, 0);
        send_byte(8'hef, 0);
        send_byte(8'h01, 0);
        send_byte(8'h23, 0);
        send_byte(8'h45, 0);
        send_byte(8'h67, 0);
        cyc();
        cyc();
        @(negedge clk);
        chk("t6_nwrites", 32'(log_a.size()), 32'd2);
        chk("t6_w0", log_d[0], 32'hdeadbeef);
        chk("t6_w1", log_d[1], 32'h01234567);
        chk("t6_done", 32'(done_cnt - d0), 32'd1);
        chk("t6_qempty", 32'(exp_a.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
